// File: rtl/rv_pkg.sv
// rv_pkg -- shared RV32 decode constants for the immediate generator.
//   OPC_*       : 7-bit major opcodes recognised by the decoder
//   fmt_e       : instruction format code carried on out_fmt
//   xlen_legal  : elaboration-time check of the datapath width
package rv_pkg;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_ILL = 3'd7
    } fmt_e;

    function automatic bit xlen_legal(input int unsigned xlen);
        return (xlen == 32) || (xlen == 64);
    endfunction

endpackage

// File: rtl/imm_decode.sv
// imm_decode -- combinational RV32 immediate extraction.
//   inst_i    [31:0]     raw instruction word
//   imm_o     [XLEN-1:0] immediate, sign-extended from inst[31]
//                        (shift amounts of slli/srli/srai are zero-extended)
//   fmt_o     [2:0]      format code (fmt_e)
//   illegal_o            opcode not recognised
module imm_decode
    import rv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst_i,
    output logic [XLEN-1:0] imm_o,
    output fmt_e            fmt_o,
    output logic            illegal_o
);

    logic signed [31:0] imm32;
    logic [5:0]         shamt;
    logic               zext;

    // RV64 shifts use a 6-bit shamt; RV32 ignores inst[25].
    assign shamt = (XLEN == 64) ? inst_i[25:20] : {1'b0, inst_i[24:20]};

    always_comb begin
        imm32     = '0;
        zext      = 1'b0;
        fmt_o     = FMT_ILL;
        illegal_o = 1'b1;
        case (inst_i[6:0])
            OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM: begin
                fmt_o     = FMT_I;
                illegal_o = 1'b0;
                imm32     = {{20{inst_i[31]}}, inst_i[31:20]};
                zext      = (inst_i[6:0] == OPC_OP_IMM) &&
                            ((inst_i[14:12] == 3'b001) || (inst_i[14:12] == 3'b101));
            end
            OPC_STORE: begin
                fmt_o     = FMT_S;
                illegal_o = 1'b0;
                imm32     = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
            end
            OPC_BRANCH: begin
                fmt_o     = FMT_B;
                illegal_o = 1'b0;
                imm32     = {{19{inst_i[31]}}, inst_i[31], inst_i[7],
                             inst_i[30:25], inst_i[11:8], 1'b0};
            end
            OPC_LUI, OPC_AUIPC: begin
                fmt_o     = FMT_U;
                illegal_o = 1'b0;
                imm32     = {inst_i[31:12], 12'b0};
            end
            OPC_JAL: begin
                fmt_o     = FMT_J;
                illegal_o = 1'b0;
                imm32     = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12],
                             inst_i[20], inst_i[30:21], 1'b0};
            end
            OPC_OP: begin
                fmt_o     = FMT_R;
                illegal_o = 1'b0;
            end
            default: ;
        endcase

        // Signed cast sign-extends to XLEN; the unsigned shamt cast zero-extends.
        if (zext) imm_o = XLEN'(shamt);
        else      imm_o = XLEN'(imm32);
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe -- one-cycle registered immediate generator with handshake.
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    input handshake, in_inst [31:0] instruction word
//   flush                synchronous discard of held and incoming entries
//   out_valid/out_ready  output handshake
//   out_imm [XLEN-1:0]   immediate, out_fmt [2:0] format, out_illegal flag
//   illegal_cnt [15:0]   saturating count of accepted illegal instructions
// SKID=1 adds a second entry so in_ready can come straight from a flop.
module imm_gen_pipe
    import rv_pkg::*;
#(
    parameter int XLEN = 32,
    parameter bit SKID = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal,
    output logic [15:0]     illegal_cnt
);

    if (!xlen_legal(XLEN)) begin : g_bad_xlen
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end

    logic [XLEN-1:0] dec_imm;
    fmt_e            dec_fmt;
    logic            dec_ill;

    imm_decode #(.XLEN(XLEN)) u_dec (
        .inst_i    (in_inst),
        .imm_o     (dec_imm),
        .fmt_o     (dec_fmt),
        .illegal_o (dec_ill)
    );

    logic            out_vld_q, out_vld_d;
    logic [XLEN-1:0] out_imm_q, out_imm_d;
    fmt_e            out_fmt_q, out_fmt_d;
    logic            out_ill_q, out_ill_d;
    logic            sk_vld_q,  sk_vld_d;
    logic [XLEN-1:0] sk_imm_q,  sk_imm_d;
    fmt_e            sk_fmt_q,  sk_fmt_d;
    logic            sk_ill_q,  sk_ill_d;
    logic            rdy_q,     rdy_d;
    logic [15:0]     cnt_q,     cnt_d;
    logic            in_xfer;
    logic            slot_free;

    assign in_ready  = SKID ? rdy_q : (!out_vld_q || out_ready);
    assign in_xfer   = in_valid && in_ready;
    // Output register may be overwritten: empty, or being consumed this cycle.
    assign slot_free = !out_vld_q || out_ready;

    always_comb begin
        out_vld_d = out_vld_q;
        out_imm_d = out_imm_q;
        out_fmt_d = out_fmt_q;
        out_ill_d = out_ill_q;
        sk_vld_d  = sk_vld_q;
        sk_imm_d  = sk_imm_q;
        sk_fmt_d  = sk_fmt_q;
        sk_ill_d  = sk_ill_q;
        cnt_d     = cnt_q;

        if (flush) begin
            out_vld_d = 1'b0;
            sk_vld_d  = 1'b0;
        end else if (slot_free) begin
            // A parked entry is older than anything arriving, so it goes first.
            // in_ready is low whenever the skid entry is full, so no input is lost.
            if (sk_vld_q) begin
                out_vld_d = 1'b1;
                out_imm_d = sk_imm_q;
                out_fmt_d = sk_fmt_q;
                out_ill_d = sk_ill_q;
                sk_vld_d  = 1'b0;
            end else if (in_xfer) begin
                out_vld_d = 1'b1;
                out_imm_d = dec_imm;
                out_fmt_d = dec_fmt;
                out_ill_d = dec_ill;
            end else begin
                out_vld_d = 1'b0;
            end
        end else if (SKID && in_xfer) begin
            sk_vld_d = 1'b1;
            sk_imm_d = dec_imm;
            sk_fmt_d = dec_fmt;
            sk_ill_d = dec_ill;
        end

        if (in_xfer && dec_ill && !flush && (cnt_q != 16'hFFFF))
            cnt_d = cnt_q + 16'd1;

        rdy_d = !sk_vld_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_q <= 1'b0;
            out_imm_q <= '0;
            out_fmt_q <= FMT_R;
            out_ill_q <= 1'b0;
            sk_vld_q  <= 1'b0;
            rdy_q     <= 1'b1;
            cnt_q     <= '0;
        end else begin
            out_vld_q <= out_vld_d;
            out_imm_q <= out_imm_d;
            out_fmt_q <= out_fmt_d;
            out_ill_q <= out_ill_d;
            sk_vld_q  <= sk_vld_d;
            rdy_q     <= rdy_d;
            cnt_q     <= cnt_d;
        end
    end

    // Skid payload is qualified by sk_vld_q, so it needs no reset.
    always_ff @(posedge clk) begin
        sk_imm_q <= sk_imm_d;
        sk_fmt_q <= sk_fmt_d;
        sk_ill_q <= sk_ill_d;
    end

    assign out_valid   = out_vld_q;
    assign out_imm     = out_imm_q;
    assign out_fmt     = out_fmt_q;
    assign out_illegal = out_ill_q;
    assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_inst;
    logic        flush;
    logic        out_ready;

    logic        in_ready,    in_ready64;
    logic        out_valid,   out_valid64;
    logic [31:0] out_imm;
    logic [63:0] out_imm64;
    logic [2:0]  out_fmt,     out_fmt64;
    logic        out_illegal, out_illegal64;
    logic [15:0] illegal_cnt, illegal_cnt64;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .SKID(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_imm(out_imm), .out_fmt(out_fmt), .out_illegal(out_illegal),
        .illegal_cnt(illegal_cnt)
    );

    imm_gen_pipe #(.XLEN(64), .SKID(1'b1)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready64),
        .in_inst(in_inst), .flush(flush), .out_valid(out_valid64), .out_ready(out_ready),
        .out_imm(out_imm64), .out_fmt(out_fmt64), .out_illegal(out_illegal64),
        .illegal_cnt(illegal_cnt64)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic xfer(input logic [31:0] w);
        in_valid = 1'b1;
        in_inst  = w;
        cyc();
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_inst = '0; flush = 1'b0; out_ready = 1'b0;
        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_imm", 64'(out_imm), 64'd0);
        check("rst_out_fmt", 64'(out_fmt), 64'd0);
        check("rst_out_illegal", 64'(out_illegal), 64'd0);
        check("rst_cnt", 64'(illegal_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;

        // Decode vectors under continuous flow
        xfer(32'hFFF00093);
        check("addi_valid", 64'(out_valid), 64'd1);
        check("addi_imm", 64'(out_imm), 64'hFFFFFFFF);
        check("addi_fmt", 64'(out_fmt), 64'd1);
        check("addi_imm64", out_imm64, 64'hFFFFFFFFFFFFFFFF);
        xfer(32'hFE000EE3);
        check("beq_imm", 64'(out_imm), 64'hFFFFFFFC);
        check("beq_fmt", 64'(out_fmt), 64'd3);
        check("beq_imm64", out_imm64, 64'hFFFFFFFFFFFFFFFC);
        xfer(32'hFE20AC23);
        check("sw_imm", 64'(out_imm), 64'hFFFFFFF8);
        check("sw_fmt", 64'(out_fmt), 64'd2);
        xfer(32'h123450B7);
        check("lui_imm", 64'(out_imm), 64'h12345000);
        check("lui_fmt", 64'(out_fmt), 64'd4);
        check("lui_imm64", out_imm64, 64'h0000000012345000);
        xfer(32'h0010006F);
        check("jal_imm", 64'(out_imm), 64'h00000800);
        check("jal_fmt", 64'(out_fmt), 64'd5);
        check("jal_imm64", out_imm64, 64'h0000000000000800);
        xfer(32'h002081B3);
        check("add_imm", 64'(out_imm), 64'd0);
        check("add_fmt", 64'(out_fmt), 64'd0);
        check("add_illegal", 64'(out_illegal), 64'd0);
        xfer(32'h4210D093);
        check("srai_imm32", 64'(out_imm), 64'h1);
        check("srai_imm64", out_imm64, 64'h21);
        check("srai_fmt", 64'(out_fmt), 64'd1);
        xfer(32'h0000007F);
        check("ill_flag", 64'(out_illegal), 64'd1);
        check("ill_fmt", 64'(out_fmt), 64'd7);
        check("ill_imm", 64'(out_imm), 64'd0);
        check("ill_cnt", 64'(illegal_cnt), 64'd1);
        cyc();
        check("idle_valid", 64'(out_valid), 64'd0);

        // Stall with three words offered
        out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'h00500093;
        cyc();
        check("st1_imm", 64'(out_imm), 64'd5);
        check("st1_ready", 64'(in_ready), 64'd1);
        in_inst = 32'h00600093;
        cyc();
        check("st2_ready", 64'(in_ready), 64'd0);
        check("st2_imm", 64'(out_imm), 64'd5);
        in_inst = 32'h00700093;
        cyc();
        check("st3_valid", 64'(out_valid), 64'd1);
        check("st3_imm", 64'(out_imm), 64'd5);
        check("st3_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        cyc();
        check("rel1_imm", 64'(out_imm), 64'd6);
        check("rel1_ready", 64'(in_ready), 64'd1);
        cyc();
        check("rel2_imm", 64'(out_imm), 64'd7);
        check("rel2_valid", 64'(out_valid), 64'd1);
        in_valid = 1'b0;
        cyc();
        check("rel3_valid", 64'(out_valid), 64'd0);

        // Flush with both entries full, then flush discarding an illegal input
        out_ready = 1'b0;
        xfer(32'h00500093);
        xfer(32'h00600093);
        check("fl_full_ready", 64'(in_ready), 64'd0);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        check("fl_valid", 64'(out_valid), 64'd0);
        check("fl_ready", 64'(in_ready), 64'd1);
        flush = 1'b1; in_valid = 1'b1; in_inst = 32'h0000007F;
        cyc();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_in_valid", 64'(out_valid), 64'd0);
        check("fl_in_cnt", 64'(illegal_cnt), 64'd1);
        out_ready = 1'b1;
        xfer(32'h123450B7);
        check("fl_after_imm", 64'(out_imm), 64'h12345000);
        cyc();

        // Reset pulse during a full stall
        out_ready = 1'b0;
        xfer(32'h00500093);
        xfer(32'h00600093);
        check("rs_full_valid", 64'(out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rs_valid", 64'(out_valid), 64'd0);
        check("rs_ready", 64'(in_ready), 64'd1);
        check("rs_cnt", 64'(illegal_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        xfer(32'hFFF00093);
        check("rs_after_imm", 64'(out_imm), 64'hFFFFFFFF);
        check("rs_after_fmt", 64'(out_fmt), 64'd1);

        // Counter saturation
        in_valid = 1'b1; in_inst = 32'h0000007F;
        repeat (65534) @(posedge clk);
        #1;
        check("sat_fffe", 64'(illegal_cnt), 64'hFFFE);
        cyc();
        check("sat_ffff", 64'(illegal_cnt), 64'hFFFF);
        repeat (3) cyc();
        check("sat_hold", 64'(illegal_cnt), 64'hFFFF);
        check("sat_hold64", 64'(illegal_cnt64), 64'hFFFF);
        in_valid = 1'b0;
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath width; legal values 32 and 64.
REQ-002 SHALL have parameter SKID, default 1, meaning 1 = two-entry skid buffer, 0 = single output register.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  meaning asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  meaning in_inst is valid.
REQ-006 SHALL have port in_ready  output  1  meaning the block accepts in_inst this cycle.
REQ-007 SHALL have port in_inst  input  32  meaning raw RV32 instruction word.
REQ-008 SHALL have port flush  input  1  meaning synchronous discard of all held and incoming entries.
REQ-009 SHALL have port out_valid  output  1  meaning the output bundle is valid.
REQ-010 SHALL have port out_ready  input  1  meaning the consumer accepts the bundle.
REQ-011 SHALL have port out_imm  output  XLEN  meaning the sign-extended immediate.
REQ-012 SHALL have port out_fmt  output  3  meaning format code: 0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 7 illegal.
REQ-013 SHALL have port out_illegal  output  1  meaning the opcode is not recognised.
REQ-014 SHALL have port illegal_cnt  output  16  meaning saturating count of illegal instructions accepted.

Function
REQ-015 Input transfer SHALL occur when in_valid && in_ready; output transfer SHALL occur when out_valid && out_ready.
REQ-016 Latency SHALL be exactly one cycle from input transfer to out_valid, with no bubble under continuous flow.
REQ-017 Opcode decode SHALL be: I = 0010011, 0000011, 1100111, 1110011; S = 0100011; B = 1100011; U = 0110111, 0010111; J = 1101111; R = 0110011 (imm 0); any other opcode is illegal (imm 0, fmt 7).
REQ-018 Immediates SHALL be: I = inst[31:20]; S = {inst[31:25], inst[11:7]}; B = {inst[31], inst[7], inst[30:25], inst[11:8], 0}; U = {inst[31:12], 12 zeros}; J = {inst[31], inst[19:12], inst[20], inst[30:21], 0}; all sign-extended from inst[31] to XLEN.
REQ-019 For opcode 0010011 with funct3 001 or 101, imm SHALL be the zero-extended shamt: inst[24:20] when XLEN=32, inst[25:20] when XLEN=64.
REQ-020 While out_valid && !out_ready, out_imm/out_fmt/out_illegal SHALL hold stable.
REQ-021 With SKID=1, in_ready SHALL be a registered signal, equal to "skid entry empty"; an input accepted while the output stalls is parked in the skid entry, and order SHALL be preserved.
REQ-022 With SKID=0, in_ready SHALL equal !out_valid || out_ready.
REQ-023 A flush SHALL clear out_valid and the skid entry on the next edge; an input transferred in the flush cycle SHALL be discarded and SHALL NOT increment illegal_cnt.
REQ-024 illegal_cnt SHALL increment on input transfer of an illegal instruction and SHALL saturate at 0xFFFF.
REQ-025 Simultaneous output transfer and input transfer SHALL replace the output entry with no loss or duplication.

Reset
REQ-026 On rst_n low, asynchronously: out_valid=0, skid empty, in_ready=1 (SKID=1), out_imm=0, out_fmt=0, out_illegal=0, illegal_cnt=0.
REQ-027 Reset asserted mid-stall SHALL drop all held entries; the first input after release SHALL be decoded normally.

Structure
REQ-028 Opcode constants, format codes and the XLEN legality check SHALL live in the shared package rv_pkg.
REQ-029 Combinational decode SHALL be the sub-module imm_decode (inst -> imm, fmt, illegal); imm_gen_pipe adds the handshake, buffering and counter.

Verification
REQ-030 0xFFF00093 (addi x1,x0,-1) -> out_imm 0xFFFFFFFF, fmt 1, one cycle later.
REQ-031 0xFE000EE3 (beq -4) -> 0xFFFFFFFC, fmt 3; 0xFE20AC23 (sw -8) -> 0xFFFFFFF8, fmt 2.
REQ-032 0x123450B7 (lui) -> 0x12345000, fmt 4; 0x0010006F (jal +2048) -> 0x00000800, fmt 5; XLEN=64 repeat -> upper word sign-matched.
REQ-033 0x0000007F -> out_illegal 1, fmt 7, imm 0, illegal_cnt 1; after 65536 illegal inputs -> illegal_cnt stays 0xFFFF.
REQ-034 SKID=1: out_ready low for 3 cycles, in_valid high with 3 distinct words -> 2 accepted, in_ready falls, output stable; release -> both emitted in order, third accepted.
REQ-035 Flush or rst_n pulse during stall with both entries full -> out_valid 0 next cycle (asynchronous for reset), counter unchanged by discarded input.
